// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin sharing of one uart_tx between NUM_REQ byte-stream requesters, one whole packet per grant.
// Latency: grant/ack/o_txBegin 1 cycle after i_req; next byte of a packet 1 + GAP_CYCLES cycles after i_txDone.
// Backpressure: a requester holds its byte until o_ack; o_txBegin and o_txData hold until uart_tx reports i_txBusy.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 0
) (
    input  logic                   i_clock,
    input  logic                   i_resetN,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [8*NUM_REQ-1:0]   i_data,
    input  logic [NUM_REQ-1:0]     i_last,
    output logic [NUM_REQ-1:0]     o_ack,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_txBegin,
    output logic [7:0]             o_txData,
    input  logic                   i_txBusy,
    input  logic                   i_txDone,
    output logic                   o_busy
);
    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

    state_t             state;
    logic [IDXW-1:0]    ptr;
    logic [IDXW-1:0]    grantIdx;
    logic [IDXW-1:0]    pickIdx;
    logic [IDXW-1:0]    cand;
    logic [NUM_REQ-1:0] pickOneHot;
    logic               anyReq;
    logic               lastFlag;
    logic               stepNow;
    logic [7:0]         gapCnt;

    // Round-robin search: the first requester above the pointer wins, wrapping around.
    always_comb begin
        pickIdx = '0;
        anyReq  = 1'b0;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDXW'((int'(ptr) + k) % NUM_REQ);
            if (i_req[cand]) begin
                pickIdx = cand;
                anyReq  = 1'b1;
            end
        end
        pickOneHot          = '0;
        pickOneHot[pickIdx] = 1'b1;
    end

    // The packet-continuation decision happens either straight on i_txDone or at the end of the gap.
    assign stepNow = ((state == SEND) && i_txDone && (GAP_CYCLES == 0)) ||
                     ((state == GAP) && (gapCnt == GAP_LAST));

    // Arbitration / byte sequencing FSM with registered outputs.
    always_ff @(posedge i_clock) begin
        if (!i_resetN) begin
            state     <= IDLE;
            ptr       <= IDXW'(NUM_REQ - 1);
            grantIdx  <= '0;
            lastFlag  <= 1'b0;
            gapCnt    <= '0;
            o_ack     <= '0;
            o_grant   <= '0;
            o_txBegin <= 1'b0;
            o_txData  <= '0;
            o_busy    <= 1'b0;
        end else begin
            o_ack <= '0;
            if (stepNow) begin
                if (!lastFlag && i_req[grantIdx]) begin
                    o_txData  <= i_data[{grantIdx, 3'b000} +: 8];
                    lastFlag  <= i_last[grantIdx];
                    o_ack     <= o_grant;
                    o_txBegin <= 1'b1;
                    state     <= START;
                end else begin
                    // Packet finished, or owner walked away mid-packet: release without ack.
                    ptr     <= grantIdx;
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (anyReq) begin
                            grantIdx  <= pickIdx;
                            o_grant   <= pickOneHot;
                            o_ack     <= pickOneHot;
                            o_txData  <= i_data[{pickIdx, 3'b000} +: 8];
                            lastFlag  <= i_last[pickIdx];
                            o_txBegin <= 1'b1;
                            o_busy    <= 1'b1;
                            state     <= START;
                        end
                    end
                    START: begin
                        // uart_tx may run on a slow bit tick; keep begin up until it reports busy.
                        if (i_txBusy) begin
                            o_txBegin <= 1'b0;
                            state     <= SEND;
                        end
                    end
                    SEND: begin
                        if (i_txDone) begin
                            gapCnt <= '0;
                            state  <= GAP;
                        end
                    end
                    GAP: begin
                        gapCnt <= gapCnt + 8'd1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: self-checking bench for uart_tx_arbiter with a behavioural uart_tx and packet-level reference model.
// Latency: checks cycle-exact behaviour in a vector table, then byte/grant/ack order and done-to-begin spacing.
// Backpressure: the uart_tx model holds busy for a programmable frame length after a programmable start delay.
module tb_uart_tx_arbiter;
    localparam int NR   = 3;
    localparam int ND   = 2;
    localparam int GAP1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstN    [ND];
    logic [NR-1:0]   req     [ND];
    logic [8*NR-1:0] data    [ND];
    logic [NR-1:0]   last    [ND];
    logic [NR-1:0]   ack     [ND];
    logic [NR-1:0]   grant   [ND];
    logic            txBegin [ND];
    logic [7:0]      txData  [ND];
    logic            txBusy  [ND];
    logic            txDone  [ND];
    logic            busy    [ND];

    uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(0)) dut0 (
        .i_clock(clk), .i_resetN(rstN[0]), .i_req(req[0]), .i_data(data[0]), .i_last(last[0]),
        .o_ack(ack[0]), .o_grant(grant[0]), .o_txBegin(txBegin[0]), .o_txData(txData[0]),
        .i_txBusy(txBusy[0]), .i_txDone(txDone[0]), .o_busy(busy[0]));

    uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP1)) dut1 (
        .i_clock(clk), .i_resetN(rstN[1]), .i_req(req[1]), .i_data(data[1]), .i_last(last[1]),
        .o_ack(ack[1]), .o_grant(grant[1]), .o_txBegin(txBegin[1]), .o_txData(txData[1]),
        .i_txBusy(txBusy[1]), .i_txDone(txDone[1]), .o_busy(busy[1]));

    typedef struct packed {
        logic [NR-1:0]   req;
        logic [8*NR-1:0] dat;
        logic [NR-1:0]   lst;
        logic            bsy;
        logic            dne;
        logic [NR-1:0]   eGrant;
        logic [NR-1:0]   eAck;
        logic            eBegin;
        logic [7:0]      eData;
        logic            chkData;
        logic            eBusy;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ohViol = 0;
    bit reqAuto = 1'b0;
    bit uartAuto = 1'b0;
    int uLat = 1;
    int uLen = 3;

    logic [8:0] rq       [ND][NR][$];
    logic [7:0] sentLog  [ND][$];
    int         grantLog [ND][$];
    logic [7:0] expByte  [ND][$];
    int         expGrant [ND][$];
    int         ackCnt   [ND][NR];
    int         expAck   [ND][NR];
    int         uPh      [ND];
    int         uCnt     [ND];
    int         doneTick [ND];
    bit         pendDone [ND];
    int         gapSeen  [ND];
    int         ptrM     [ND];
    logic [NR-1:0] prevGrant [ND];
    logic          prevBegin [ND];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int gapOf(input int d);
        return (d == 0) ? 0 : GAP1;
    endfunction

    function automatic int idxOf(input logic [NR-1:0] g);
        int r;
        r = -1;
        for (int k = 0; k < NR; k++) if (g[k]) r = k;
        return r;
    endfunction

    // Requester k presents the head of its queue; an empty queue means request low.
    task automatic driveReq(input int d);
        logic [8:0] e;
        for (int k = 0; k < NR; k++) begin
            if (rq[d][k].size() > 0) begin
                e = rq[d][k][0];
                req[d][k] = 1'b1;
                data[d][8*k +: 8] = e[7:0];
                last[d][k] = e[8];
            end else begin
                req[d][k] = 1'b0;
                data[d][8*k +: 8] = 8'h00;
                last[d][k] = 1'b0;
            end
        end
    endtask

    // Behavioural uart_tx: start delay, busy frame, one-cycle done pulse.
    task automatic uartStep(input int d);
        case (uPh[d])
            0: if (txBegin[d]) begin uPh[d] = 1; uCnt[d] = uLat; end
            1: begin
                if (uCnt[d] == 0) begin
                    txBusy[d] = 1'b1;
                    sentLog[d].push_back(txData[d]);
                    uCnt[d] = uLen;
                    uPh[d] = 2;
                end else uCnt[d]--;
            end
            2: begin
                if (uCnt[d] <= 1) begin
                    txBusy[d] = 1'b0;
                    txDone[d] = 1'b1;
                    doneTick[d] = cyc;
                    pendDone[d] = 1'b1;
                    uPh[d] = 3;
                end else uCnt[d]--;
            end
            default: begin txDone[d] = 1'b0; uPh[d] = 0; end
        endcase
    endtask

    task automatic tick();
        logic [8:0] t;
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < ND; d++) begin
            if (!$onehot0(grant[d])) ohViol++;
            if (grant[d] == '0) pendDone[d] = 1'b0;
            if (prevGrant[d] == '0 && grant[d] != '0) grantLog[d].push_back(idxOf(grant[d]));
            if (txBegin[d] && !prevBegin[d] && pendDone[d]) begin
                chk($sformatf("done_to_begin_d%0d", d), cyc - doneTick[d], gapOf(d) + 1);
                gapSeen[d]++;
                pendDone[d] = 1'b0;
            end
            prevGrant[d] = grant[d];
            prevBegin[d] = txBegin[d];
            for (int k = 0; k < NR; k++) begin
                if (ack[d][k]) begin
                    ackCnt[d][k]++;
                    if (reqAuto && rq[d][k].size() > 0) t = rq[d][k].pop_front();
                end
            end
            if (uartAuto) uartStep(d);
            if (reqAuto) driveReq(d);
        end
    endtask

    task automatic doReset();
        reqAuto = 1'b0;
        uartAuto = 1'b0;
        for (int d = 0; d < ND; d++) begin
            rstN[d] = 1'b0; req[d] = '0; data[d] = '0; last[d] = '0;
            txBusy[d] = 1'b0; txDone[d] = 1'b0; uPh[d] = 0; pendDone[d] = 1'b0;
            for (int k = 0; k < NR; k++) rq[d][k].delete();
            ptrM[d] = NR - 1;
        end
        tick();
        tick();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_grant_d%0d", d), int'(grant[d]), 0);
            chk($sformatf("rst_ack_d%0d", d), int'(ack[d]), 0);
            chk($sformatf("rst_begin_d%0d", d), int'(txBegin[d]), 0);
            chk($sformatf("rst_data_d%0d", d), int'(txData[d]), 0);
            chk($sformatf("rst_busy_d%0d", d), int'(busy[d]), 0);
            rstN[d] = 1'b1;
        end
        tick();
    endtask

    // Packet-level reference: round-robin over requesters with pending bytes, whole packet per grant.
    task automatic predict(input int d);
        logic [8:0] q [NR][$];
        logic [8:0] e;
        int p, pick;
        bit more, inPkt;
        for (int k = 0; k < NR; k++) begin q[k] = rq[d][k]; expAck[d][k] = 0; end
        expByte[d].delete();
        expGrant[d].delete();
        p = ptrM[d];
        more = 1'b1;
        while (more) begin
            pick = -1;
            for (int off = 1; off <= NR; off++)
                if (pick < 0 && q[(p + off) % NR].size() > 0) pick = (p + off) % NR;
            if (pick < 0) more = 1'b0;
            else begin
                expGrant[d].push_back(pick);
                inPkt = 1'b1;
                while (inPkt) begin
                    e = q[pick].pop_front();
                    expByte[d].push_back(e[7:0]);
                    expAck[d][pick]++;
                    inPkt = !e[8] && (q[pick].size() > 0);
                end
                p = pick;
            end
        end
        ptrM[d] = p;
    endtask

    function automatic bit allIdle();
        bit r;
        r = 1'b1;
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < NR; k++) if (rq[d][k].size() > 0) r = 1'b0;
            if (grant[d] != '0 || busy[d] || uPh[d] != 0) r = 1'b0;
        end
        return r;
    endfunction

    task automatic runScen(input string tag, input int budget);
        int n;
        for (int d = 0; d < ND; d++) begin
            predict(d);
            sentLog[d].delete();
            grantLog[d].delete();
            for (int k = 0; k < NR; k++) ackCnt[d][k] = 0;
        end
        uartAuto = 1'b1;
        reqAuto = 1'b1;
        for (int d = 0; d < ND; d++) driveReq(d);
        n = 0;
        while (!allIdle() && n < budget) begin tick(); n++; end
        chk({tag, "_complete"}, int'(allIdle()), 1);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s_nbytes_d%0d", tag, d), sentLog[d].size(), expByte[d].size());
            for (int i = 0; i < expByte[d].size(); i++)
                chk($sformatf("%s_byte%0d_d%0d", tag, i, d),
                    (i < sentLog[d].size()) ? int'(sentLog[d][i]) : -1, int'(expByte[d][i]));
            chk($sformatf("%s_ngrants_d%0d", tag, d), grantLog[d].size(), expGrant[d].size());
            for (int i = 0; i < expGrant[d].size(); i++)
                chk($sformatf("%s_grant%0d_d%0d", tag, i, d),
                    (i < grantLog[d].size()) ? grantLog[d][i] : -1, expGrant[d][i]);
            for (int k = 0; k < NR; k++)
                chk($sformatf("%s_acks_r%0d_d%0d", tag, k, d), ackCnt[d][k], expAck[d][k]);
        end
    endtask

    task automatic randomScen(input int it);
        int npk, len;
        bit lastOne;
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < NR; k++) begin
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 3);
                    lastOne = !((p == npk - 1) && ($urandom_range(0, 3) == 0));
                    for (int b = 0; b < len; b++)
                        rq[d][k].push_back({(b == len - 1) ? lastOne : 1'b0, 8'($urandom)});
                end
            end
        end
        uLat = $urandom_range(0, 3);
        uLen = $urandom_range(1, 5);
        runScen($sformatf("rand%0d", it), 2000);
    endtask

    vec_t tbl [6];
    int   pat [6];

    initial begin
        int n, stale;
        for (int d = 0; d < ND; d++) begin
            rstN[d] = 1'b0; req[d] = '0; data[d] = '0; last[d] = '0;
            txBusy[d] = 1'b0; txDone[d] = 1'b0; prevGrant[d] = '0; prevBegin[d] = 1'b0;
            gapSeen[d] = 0; uPh[d] = 0; uCnt[d] = 0; doneTick[d] = 0;
        end
        //            req     data          last    bsy   dne   grant   ack     begin txData chk  busy
        tbl[0] = '{3'b001, 24'h0000CC, 3'b001, 1'b0, 1'b0, 3'b001, 3'b001, 1'b1, 8'hCC, 1'b1, 1'b1};
        tbl[1] = '{3'b000, 24'h000000, 3'b000, 1'b0, 1'b1, 3'b001, 3'b000, 1'b1, 8'hCC, 1'b1, 1'b1};
        tbl[2] = '{3'b010, 24'h005500, 3'b010, 1'b1, 1'b0, 3'b001, 3'b000, 1'b0, 8'hCC, 1'b1, 1'b1};
        tbl[3] = '{3'b010, 24'h005500, 3'b010, 1'b1, 1'b0, 3'b001, 3'b000, 1'b0, 8'hCC, 1'b1, 1'b1};
        tbl[4] = '{3'b000, 24'h000000, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{3'b000, 24'h000000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0};
        pat = '{0, 1, 0, 1, 0, 1};

        doReset();

        // Single-byte packet, cycle by cycle, with a stray done in START and a foreign request in SEND.
        for (int i = 0; i < 6; i++) begin
            req[0] = tbl[i].req; data[0] = tbl[i].dat; last[0] = tbl[i].lst;
            txBusy[0] = tbl[i].bsy; txDone[0] = tbl[i].dne;
            tick();
            chk($sformatf("vec%0d_grant", i), int'(grant[0]), int'(tbl[i].eGrant));
            chk($sformatf("vec%0d_ack", i), int'(ack[0]), int'(tbl[i].eAck));
            chk($sformatf("vec%0d_begin", i), int'(txBegin[0]), int'(tbl[i].eBegin));
            if (tbl[i].chkData) chk($sformatf("vec%0d_txdata", i), int'(txData[0]), int'(tbl[i].eData));
            chk($sformatf("vec%0d_busy", i), int'(busy[0]), int'(tbl[i].eBusy));
        end
        ptrM[0] = 0;

        // Three-byte packet from requester 1, then pointer must sit at 1 so requester 2 beats 0.
        rq[0][1].push_back({1'b0, 8'hDD});
        rq[0][1].push_back({1'b0, 8'hEE});
        rq[0][1].push_back({1'b1, 8'h0A});
        runScen("pkt3", 400);
        chk("pkt3_single_grant", grantLog[0].size(), 1);
        chk("pkt3_acks", ackCnt[0][1], 3);
        rq[0][0].push_back({1'b1, 8'h5A});
        rq[0][2].push_back({1'b1, 8'hA5});
        runScen("ptr1", 400);
        chk("ptr1_first", (grantLog[0].size() > 0) ? grantLog[0][0] : -1, 2);

        // Two requesters continuously asking: strict alternation from reset.
        doReset();
        for (int i = 0; i < 3; i++) begin
            rq[0][0].push_back({1'b1, 8'(8'h30 + i)});
            rq[0][1].push_back({1'b1, 8'(8'h40 + i)});
        end
        runScen("alt", 600);
        for (int i = 0; i < 6; i++)
            chk($sformatf("alt_order%0d", i), (grantLog[0].size() > i) ? grantLog[0][i] : -1, pat[i]);

        // Requester 0 abandons its packet after one byte while requester 1 waits.
        doReset();
        rq[0][0].push_back({1'b0, 8'h71});
        rq[0][1].push_back({1'b1, 8'h81});
        runScen("abort", 400);
        chk("abort_acks0", ackCnt[0][0], 1);
        chk("abort_next", (grantLog[0].size() > 1) ? grantLog[0][1] : -1, 1);

        // Two-byte packet on both instances: done-to-begin spacing of 1 and GAP1+1 cycles.
        doReset();
        for (int d = 0; d < ND; d++) begin
            rq[d][0].push_back({1'b0, 8'hA1});
            rq[d][0].push_back({1'b1, 8'hA2});
        end
        runScen("gap", 400);
        chk("gap_seen_d0", int'(gapSeen[0] > 0), 1);
        chk("gap_seen_d1", int'(gapSeen[1] > 0), 1);

        // Reset during SEND: outputs drop next edge, stale done ignored, pointer back to requester 0 first.
        doReset();
        rq[0][0].push_back({1'b1, 8'h11});
        runScen("pre_rst", 300);
        uLen = 20;
        rq[0][0].push_back({1'b1, 8'h22});
        uartAuto = 1'b1;
        reqAuto = 1'b1;
        driveReq(0);
        n = 0;
        while (!(grant[0] != '0 && !txBegin[0] && uPh[0] == 2) && n < 100) begin tick(); n++; end
        chk("rst_reach_send", int'(n < 100), 1);
        rstN[0] = 1'b0;
        tick();
        chk("midrst_grant", int'(grant[0]), 0);
        chk("midrst_begin", int'(txBegin[0]), 0);
        chk("midrst_busy", int'(busy[0]), 0);
        rstN[0] = 1'b1;
        ptrM[0] = NR - 1;
        n = 0;
        stale = 0;
        while (uPh[0] != 0 && n < 100) begin tick(); if (busy[0] || grant[0] != '0) stale++; n++; end
        tick();
        if (busy[0] || grant[0] != '0) stale++;
        chk("stale_done_ignored", stale, 0);
        uLen = 3;
        rq[0][0].push_back({1'b1, 8'h33});
        rq[0][1].push_back({1'b1, 8'h44});
        runScen("post_rst", 400);
        chk("post_rst_first", (grantLog[0].size() > 0) ? grantLog[0][0] : -1, 0);

        // Randomised packets, frame timing and aborts against the reference model.
        doReset();
        for (int it = 0; it < 25; it++) randomScen(it);

        chk("grant_onehot", ohViol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
